// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg: shared types and helpers for sram_dp_be.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MAX_DW = 256;
  localparam int MAX_NB = MAX_DW;

  function automatic int lane_count(input int dw, input int bw);
    return dw / bw;
  endfunction

  // Lanes are bw bits wide; bw=1 turns this into a plain bit-mask merge.
  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_NB-1:0] be,
    input int                bw
  );
    logic [MAX_DW-1:0] res;
    int                lane;
    res = old_w;
    for (int k = 0; k < MAX_DW; k++) begin
      lane = k / bw;
      if (lane < MAX_NB && be[lane[7:0]]) res[k] = new_w[k];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_rd_pipe.sv
// ---------------------------------------------------------------------------
// sram_rd_pipe: LATENCY-deep valid/data pipeline, data held between reads.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_rd_pipe #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [LATENCY-1:0] vld_q;
  logic [WIDTH-1:0]   dat_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      if (valid_i) dat_q[0] <= data_i;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[LATENCY-1];
  assign data_o  = dat_q[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/sram_dp_be.sv
// ---------------------------------------------------------------------------
// sram_dp_be: 1W/1R byte-enable SRAM with post-reset clearing sweep.
// Define SRAM_DP_BE_PARITY_EN for per-lane parity + parity_err_o.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_dp_be
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1,
  localparam int NB          = lane_count(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [NB-1:0]         wbe_i,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] read_addr_i,
  output logic [DATA_WIDTH-1:0] q_o,
  output logic                  q_valid_o,
`ifdef SRAM_DP_BE_PARITY_EN
  output logic [NB-1:0]         parity_err_o,
`endif
  output logic                  init_busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sram_dp_be: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("sram_dp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = RUN;
    end
  end

  logic                  w_run, w_collide;
  logic [DATA_WIDTH-1:0] w_wr_word, w_rd_word;

  assign init_busy_o = (state_q == INIT);
  assign w_run       = (state_q == RUN);
  assign w_wr_word   = DATA_WIDTH'(lane_merge(MAX_DW'(mem_q[write_addr_i]),
                                              MAX_DW'(data_i),
                                              MAX_NB'(wbe_i), BYTE_WIDTH));
  // A same-address write lands on the array at this edge, so the read side
  // only sees it through the merged word.
  assign w_collide   = (BYPASS != 0) && we_i && (write_addr_i == read_addr_i);
  assign w_rd_word   = w_collide ? w_wr_word : mem_q[read_addr_i];

`ifdef SRAM_DP_BE_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] w_new_par, w_wr_par, w_rd_perr;
  logic [DATA_WIDTH+NB-1:0] w_pipe_in, w_pipe_out;
  logic                     w_pipe_vld;

  always_comb begin
    w_new_par = '0;
    w_rd_perr = '0;
    for (int i = 0; i < NB; i++) begin
      w_new_par[i] = ^data_i[i*BYTE_WIDTH +: BYTE_WIDTH];
      w_rd_perr[i] = (^mem_q[read_addr_i][i*BYTE_WIDTH +: BYTE_WIDTH]) ^ par_q[read_addr_i][i];
    end
    if (w_collide) w_rd_perr = '0;
  end

  assign w_wr_par = NB'(lane_merge(MAX_DW'(par_q[write_addr_i]), MAX_DW'(w_new_par),
                                   MAX_NB'(wbe_i), 1));

  always_ff @(posedge clk_i) begin
    if (state_q == INIT) begin
      mem_q[cnt_q] <= '0;
      par_q[cnt_q] <= '0;
    end else if (we_i) begin
      mem_q[write_addr_i] <= w_wr_word;
      par_q[write_addr_i] <= w_wr_par;
    end
  end

  assign w_pipe_in = {w_rd_perr, w_rd_word};

  sram_rd_pipe #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (DATA_WIDTH + NB)
  ) u_rd_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (w_run & re_i),
    .data_i  (w_pipe_in),
    .valid_o (w_pipe_vld),
    .data_o  (w_pipe_out)
  );

  assign q_valid_o    = w_pipe_vld;
  assign q_o          = w_pipe_out[DATA_WIDTH-1:0];
  assign parity_err_o = w_pipe_vld ? w_pipe_out[DATA_WIDTH +: NB] : '0;
`else
  always_ff @(posedge clk_i) begin
    if (state_q == INIT) mem_q[cnt_q] <= '0;
    else if (we_i) mem_q[write_addr_i] <= w_wr_word;
  end

  sram_rd_pipe #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (DATA_WIDTH)
  ) u_rd_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (w_run & re_i),
    .data_i  (w_rd_word),
    .valid_o (q_valid_o),
    .data_o  (q_o)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_dp_be.sv
// ---------------------------------------------------------------------------
// tb_sram_dp_be: directed bench; three instances share one stimulus stream.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_dp_be;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  wbe;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        re;
  logic [3:0]  raddr;

  logic [31:0] q_a, q_b, q_c;
  logic        qv_a, qv_b, qv_c;
  logic        busy_a, busy_b, busy_c;
`ifdef SRAM_DP_BE_PARITY_EN
  logic [3:0]  pe_a, pe_b, pe_c;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: latency 1, write-first; b: latency 1, read-old; c: latency 2, write-first
  sram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .READ_LATENCY(1), .BYPASS(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .wbe_i(wbe), .write_addr_i(waddr), .data_i(wdata),
    .re_i(re), .read_addr_i(raddr), .q_o(q_a), .q_valid_o(qv_a),
`ifdef SRAM_DP_BE_PARITY_EN
    .parity_err_o(pe_a),
`endif
    .init_busy_o(busy_a));

  sram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .READ_LATENCY(1), .BYPASS(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .wbe_i(wbe), .write_addr_i(waddr), .data_i(wdata),
    .re_i(re), .read_addr_i(raddr), .q_o(q_b), .q_valid_o(qv_b),
`ifdef SRAM_DP_BE_PARITY_EN
    .parity_err_o(pe_b),
`endif
    .init_busy_o(busy_b));

  sram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .READ_LATENCY(2), .BYPASS(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .wbe_i(wbe), .write_addr_i(waddr), .data_i(wdata),
    .re_i(re), .read_addr_i(raddr), .q_o(q_c), .q_valid_o(qv_c),
`ifdef SRAM_DP_BE_PARITY_EN
    .parity_err_o(pe_c),
`endif
    .init_busy_o(busy_c));

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; waddr = a; wdata = d; wbe = be;
    tick();
    we = 1'b0; wbe = 4'h0;
  endtask

  task automatic wait_init(output int n, output logic seen);
    n = 0;
    seen = 1'b0;
    while ((busy_a || busy_b || busy_c) && n < 100) begin
      tick();
      n++;
      if (qv_a || qv_b || qv_c) seen = 1'b1;
    end
  endtask

  int   n_busy;
  logic seen_qv;

  initial begin
    rst_n = 1'b0; we = 1'b0; wbe = 4'h0; waddr = '0; wdata = '0; re = 1'b0; raddr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy_a, 1'b1);
    check_eq("rst_qv",   qv_a,   1'b0);
    check_eq("rst_q",    q_a,    32'h0);
    check_eq("rst_qv_l2", qv_c,  1'b0);

    // reads requested during the sweep must be dropped
    rst_n = 1'b1; re = 1'b1; raddr = 4'd2;
    wait_init(n_busy, seen_qv);
    check_eq("init_len",   n_busy,  16);
    check_eq("init_no_qv", seen_qv, 1'b0);
    check_eq("init_busy_b", busy_b, 1'b0);

    for (int a = 0; a < 16; a++) begin
      raddr = 4'(a);
      tick();
      check_eq($sformatf("clr_q[%0d]", a), q_a, 32'h0);
      check_eq($sformatf("clr_qv[%0d]", a), qv_a, 1'b1);
    end
`ifdef SRAM_DP_BE_PARITY_EN
    check_eq("clr_perr", pe_a, 4'h0);
`endif
    re = 1'b0;
    tick();

    // byte-lane merge
    do_write(4'd3, 32'hAABBCCDD, 4'b1111);
    do_write(4'd3, 32'h11223344, 4'b0101);
    re = 1'b1; raddr = 4'd3;
    tick();
    check_eq("merge_q",    q_a,  32'hAA22CC44);
    check_eq("merge_qv",   qv_a, 1'b1);
    check_eq("merge_q_b",  q_b,  32'hAA22CC44);
    re = 1'b0;
    tick();
    check_eq("hold_qv",    qv_a, 1'b0);
    check_eq("hold_q",     q_a,  32'hAA22CC44);
    check_eq("l2_merge_q", q_c,  32'hAA22CC44);
    check_eq("l2_merge_qv", qv_c, 1'b1);
    tick();
    check_eq("l2_drop_qv", qv_c, 1'b0);

    do_write(4'd3, 32'h0, 4'b0000);
    re = 1'b1; raddr = 4'd3;
    tick();
    check_eq("wbe0_q", q_a, 32'hAA22CC44);
    re = 1'b0;
    tick();

    // same-cycle collision on addr 5 (still cleared)
    we = 1'b1; waddr = 4'd5; wdata = 32'hFFFFFFFF; wbe = 4'b0011;
    re = 1'b1; raddr = 4'd5;
    tick();
    we = 1'b0; wbe = 4'h0;
    check_eq("coll_wf_q", q_a, 32'h0000FFFF);
    check_eq("coll_ro_q", q_b, 32'h00000000);
    tick();
    check_eq("coll_l2_q",    q_c, 32'h0000FFFF);
    check_eq("after_coll_a", q_a, 32'h0000FFFF);
    check_eq("after_coll_b", q_b, 32'h0000FFFF);
    re = 1'b0;
    repeat (2) tick();

    // pipelined reads, in order
    do_write(4'd0, 32'h10, 4'hF);
    do_write(4'd1, 32'h11, 4'hF);
    do_write(4'd2, 32'h12, 4'hF);
    re = 1'b1; raddr = 4'd0;
    tick();
    check_eq("p1_l2_qv", qv_c, 1'b0);
    check_eq("p1_l1_q",  q_a,  32'h10);
    raddr = 4'd1;
    tick();
    check_eq("p2_l2_qv", qv_c, 1'b1);
    check_eq("p2_l2_q",  q_c,  32'h10);
    check_eq("p2_l1_q",  q_a,  32'h11);
    raddr = 4'd2;
    tick();
    check_eq("p3_l2_qv", qv_c, 1'b1);
    check_eq("p3_l2_q",  q_c,  32'h11);
    re = 1'b0;
    tick();
    check_eq("p4_l2_qv", qv_c, 1'b1);
    check_eq("p4_l2_q",  q_c,  32'h12);
    tick();
    check_eq("p5_l2_qv", qv_c, 1'b0);
    check_eq("p5_l2_q",  q_c,  32'h12);

    // reset with a read in flight, then again mid-sweep
    re = 1'b1; raddr = 4'd1;
    tick();
    re = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("arst_qv_l1", qv_a,   1'b0);
    check_eq("arst_q_l1",  q_a,    32'h0);
    check_eq("arst_busy",  busy_a, 1'b1);
    rst_n = 1'b1;
    seen_qv = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (qv_a || qv_b || qv_c) seen_qv = 1'b1;
    end
    check_eq("mid_busy7", busy_a, 1'b1);
    check_eq("inflight_dropped", seen_qv, 1'b0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    wait_init(n_busy, seen_qv);
    check_eq("reinit_len",   n_busy,  16);
    check_eq("reinit_no_qv", seen_qv, 1'b0);
    re = 1'b1; raddr = 4'd3;
    tick();
    check_eq("reinit_clr_q", q_a, 32'h0);
    re = 1'b0;
    tick();

`ifdef SRAM_DP_BE_PARITY_EN
    do_write(4'd9, 32'h01020304, 4'hF);
    dut_a.mem_q[9][16] = ~dut_a.mem_q[9][16];
    re = 1'b1; raddr = 4'd9;
    tick();
    check_eq("perr_lane2", pe_a, 4'b0100);
    check_eq("perr_qv",    qv_a, 1'b1);
    check_eq("perr_clean_b", pe_b, 4'b0000);
    re = 1'b0;
    tick();
    check_eq("perr_gated", pe_a, 4'b0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
